// File: rtl/eq_pkg.sv
// Shared types for the equalizer gain loader: gain word, loader FSM states, bank size limit.
package eq_pkg;

   localparam int EQ_MAX_FILTERS = 16;

   typedef logic [15:0] gain_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARM       = 3'd1,
      WAIT_SYNC = 3'd2,
      RST       = 3'd3,
      CHECK     = 3'd4,
      WR        = 3'd5,
      GAP       = 3'd6,
      DONE      = 3'd7
   } eq_ld_state_t;

endpackage

// File: rtl/eq_gain_loader_if.sv
// Write-port bundle between the gain loader (master) and the equalizer gain RAM (slave).
interface eq_gain_loader_if;

   logic       eq_wr;
   logic       eq_wr_rst;
   logic [3:0] eq_wr_sel;
   logic [7:0] eq_gain_lsb;
   logic [7:0] eq_gain_msb;
   logic       wr_addr_zero;
   logic       eq_data_valid;

   modport master (
      output eq_wr, eq_wr_rst, eq_wr_sel, eq_gain_lsb, eq_gain_msb,
      input  wr_addr_zero, eq_data_valid
   );

   modport slave (
      input  eq_wr, eq_wr_rst, eq_wr_sel, eq_gain_lsb, eq_gain_msb,
      output wr_addr_zero, eq_data_valid
   );

endinterface

// File: rtl/eq_gain_shadow.sv
// CPU-writable shadow bank of 16-bit gains, byte-granular writes, one combinational read port.
module eq_gain_shadow
   import eq_pkg::*;
#(
   parameter int    NUM        = 4,
   parameter gain_t RESET_GAIN = 16'h4000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       wr_en,
   input  logic [3:0] wr_sel,
   input  logic       wr_hi,
   input  logic [7:0] wr_data,
   input  logic [3:0] rd_sel,
   output gain_t      rd_data
);

   gain_t bank_q [NUM];
   gain_t bank_d [NUM];

   // Byte update of the selected entry; indices outside the bank match nothing.
   always_comb begin
      for (int i = 0; i < NUM; i++) begin
         bank_d[i] = bank_q[i];
         if (wr_en && (wr_sel == 4'(i))) begin
            if (wr_hi) begin
               bank_d[i][15:8] = wr_data;
            end else begin
               bank_d[i][7:0] = wr_data;
            end
         end else begin
            bank_d[i] = bank_q[i];
         end
      end
   end

   // Bank storage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM; i++) bank_q[i] <= RESET_GAIN;
      end else begin
         for (int i = 0; i < NUM; i++) bank_q[i] <= bank_d[i];
      end
   end

   // Read mux.
   always_comb begin
      rd_data = 16'h0000;
      for (int i = 0; i < NUM; i++) begin
         if (rd_sel == 4'(i)) begin
            rd_data = bank_q[i];
         end else begin
            rd_data = rd_data;
         end
      end
   end

endmodule

// File: rtl/eq_gain_loader.sv
// Streams the shadow gain bank into the equalizer's auto-incrementing write port on request.
// Build option EQ_LOAD_SYNC_EN: hold off the address reset until an eq_data_valid strobe.
module eq_gain_loader
   import eq_pkg::*;
#(
   parameter int    num_of_filters = 4,
   parameter gain_t RESET_GAIN     = 16'h4000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cpu_wr,
   input  logic [3:0]       cpu_gain_sel,
   input  logic             cpu_byte_hi,
   input  logic [7:0]       cpu_data,
   input  logic             load_req,
   eq_gain_loader_if.master eq,
   output logic             busy,
   output logic             load_done,
   output logic             sync_err
);

   localparam logic [3:0] LAST_IDX = 4'(num_of_filters - 1);

   eq_ld_state_t state_q, state_d;
   logic [3:0]   count_q, count_d;
   logic         pending_q, pending_d;
   logic         sync_err_q, sync_err_d;
   logic         wr_q, wr_d;
   logic         wr_rst_q, wr_rst_d;
   logic [3:0]   sel_q, sel_d;
   gain_t        gain_q, gain_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   gain_t        shadow_rd_s;

   eq_gain_shadow #(
      .NUM        (num_of_filters),
      .RESET_GAIN (RESET_GAIN)
   ) u_shadow (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (cpu_wr),
      .wr_sel  (cpu_gain_sel),
      .wr_hi   (cpu_byte_hi),
      .wr_data (cpu_data),
      .rd_sel  (count_d),
      .rd_data (shadow_rd_s)
   );

   // Loader FSM next state, word counter, pending request and sticky sync error.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      sync_err_d = sync_err_q;
      if (load_req && (state_q != IDLE)) begin
         pending_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end
      case (state_q)
         IDLE: begin
            if (load_req) state_d = ARM;
            else          state_d = IDLE;
         end
         ARM: begin
            count_d    = 4'd0;
            sync_err_d = 1'b0;
`ifdef EQ_LOAD_SYNC_EN
            state_d    = WAIT_SYNC;
`else
            state_d    = RST;
`endif
         end
         WAIT_SYNC: begin
`ifdef EQ_LOAD_SYNC_EN
            if (eq.eq_data_valid) state_d = RST;
            else                  state_d = WAIT_SYNC;
`else
            state_d = IDLE;
`endif
         end
         RST:   state_d = CHECK;
         CHECK: begin
            if (eq.wr_addr_zero) begin
               state_d = WR;
            end else begin
               sync_err_d = 1'b1;
               state_d    = DONE;
            end
         end
         WR:    state_d = GAP;
         GAP: begin
            count_d = count_q + 4'd1;
            if (count_q == LAST_IDX) state_d = DONE;
            else                     state_d = WR;
         end
         DONE: begin
            // A request seen at any point of this load (including now) reruns it once.
            if (pending_q || load_req) begin
               state_d   = ARM;
               pending_d = 1'b0;
            end else begin
               state_d   = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            pending_d = 1'b0;
         end
      endcase
   end

   // Output decode from the next state so every output comes straight from a flop.
   always_comb begin
      wr_d     = (state_d == WR);
      wr_rst_d = (state_d == RST);
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
      if (state_d == WR) begin
         sel_d  = count_d;
         gain_d = shadow_rd_s;
      end else begin
         sel_d  = sel_q;
         gain_d = gain_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         count_q    <= 4'd0;
         pending_q  <= 1'b0;
         sync_err_q <= 1'b0;
         wr_q       <= 1'b0;
         wr_rst_q   <= 1'b0;
         sel_q      <= 4'd0;
         gain_q     <= 16'h0000;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         pending_q  <= pending_d;
         sync_err_q <= sync_err_d;
         wr_q       <= wr_d;
         wr_rst_q   <= wr_rst_d;
         sel_q      <= sel_d;
         gain_q     <= gain_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign eq.eq_wr       = wr_q;
   assign eq.eq_wr_rst   = wr_rst_q;
   assign eq.eq_wr_sel   = sel_q;
   assign eq.eq_gain_msb = gain_q[15:8];
   assign eq.eq_gain_lsb = gain_q[7:0];
   assign busy           = busy_q;
   assign load_done      = done_q;
   assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_eq_gain_loader.sv
// Scoreboard bench for eq_gain_loader: reference shadow bank + equalizer address model.
module tb_eq_gain_loader;
   import eq_pkg::*;

   localparam int N = 4;

   typedef struct packed {
      logic [3:0] sel;
      gain_t      g;
   } word_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cpu_wr = 1'b0;
   logic [3:0] cpu_gain_sel = 4'd0;
   logic       cpu_byte_hi = 1'b0;
   logic [7:0] cpu_data = 8'd0;
   logic       load_req = 1'b0;
   logic       busy, load_done, sync_err;

   eq_gain_loader_if eqi ();

   eq_gain_loader #(.num_of_filters(N), .RESET_GAIN(16'h4000)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cpu_wr       (cpu_wr),
      .cpu_gain_sel (cpu_gain_sel),
      .cpu_byte_hi  (cpu_byte_hi),
      .cpu_data     (cpu_data),
      .load_req     (load_req),
      .eq           (eqi.master),
      .busy         (busy),
      .load_done    (load_done),
      .sync_err     (sync_err)
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_fail = 0;
   int    cyc = 0;
   gain_t shadow_m [N];
   word_t exp_w [$];
   bit    exp_d [$];
   int    n_rst = 0, n_done = 0, rst_cyc = -1, first_wr_cyc = -1, done_cyc = -1;
   int    e0 = 0;
   bit    prev_wr = 1'b0;
   bit    force_nz = 1'b0;
   bit    auto_dv = 1'b1;
   bit    dv_once = 1'b0;
   int    dv_cyc = -1;
   int    eq_addr = 1;
   gain_t eq_ram [16];

   always @(posedge clk) cyc <= cyc + 1;

   // Equalizer write port: address cleared by eq_wr_rst, advances after each write.
   always @(posedge clk) begin
      if (eqi.eq_wr_rst) begin
         eq_addr <= 0;
      end else if (eqi.eq_wr) begin
         if (eq_addr < 16) eq_ram[eq_addr] <= {eqi.eq_gain_msb, eqi.eq_gain_lsb};
         eq_addr <= eq_addr + 1;
      end
   end
   assign eqi.wr_addr_zero = (eq_addr == 0) && !force_nz;

   initial begin
      eqi.eq_data_valid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         eqi.eq_data_valid = dv_once || (auto_dv && (cyc % 7 == 0));
         if (dv_once) begin
            dv_once = 1'b0;
            dv_cyc  = cyc;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [24:0] outs();
      return {eqi.eq_wr, eqi.eq_wr_rst, eqi.eq_wr_sel, eqi.eq_gain_msb, eqi.eq_gain_lsb,
              busy, load_done, sync_err};
   endfunction

   // Monitor: pops expectations whenever the DUT presents a write or a load completion.
   always @(negedge clk) begin
      if (reset_n) begin
         if (eqi.eq_wr) begin
            word_t w;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            chk("wr_cadence", {31'd0, prev_wr}, 32'd0);
            if (exp_w.size() == 0) begin
               chk("unexpected_wr", 32'd1, 32'd0);
            end else begin
               w = exp_w.pop_front();
               chk("wr_sel", {28'd0, eqi.eq_wr_sel}, {28'd0, w.sel});
               chk("wr_gain", {16'd0, eqi.eq_gain_msb, eqi.eq_gain_lsb}, {16'd0, w.g});
            end
         end
         prev_wr = eqi.eq_wr;
         if (eqi.eq_wr_rst) begin
            n_rst++;
            rst_cyc = cyc;
         end
         if (load_done) begin
            n_done++;
            done_cyc = cyc;
            if (exp_d.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               chk("done_sync_err", {31'd0, sync_err}, {31'd0, exp_d.pop_front()});
            end
         end
      end
   end

   task automatic cpu_write(input int sel, input bit hi, input logic [7:0] data);
      cpu_gain_sel = sel[3:0];
      cpu_byte_hi  = hi;
      cpu_data     = data;
      cpu_wr       = 1'b1;
      @(posedge clk);
      #1;
      cpu_wr = 1'b0;
      if (sel < N) begin
         if (hi) shadow_m[sel][15:8] = data;
         else    shadow_m[sel][7:0]  = data;
      end
   endtask

   task automatic push_load(input bit serr);
      if (!serr) begin
         for (int i = 0; i < N; i++) exp_w.push_back('{sel: 4'(i), g: shadow_m[i]});
      end
      exp_d.push_back(serr);
   endtask

   task automatic pulse_req();
      load_req = 1'b1;
      e0 = cyc + 1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
   endtask

   task automatic do_load();
      push_load(1'b0);
      pulse_req();
   endtask

   task automatic wait_quiet();
      int k = 0;
      while ((busy || exp_w.size() != 0 || exp_d.size() != 0) && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("load_complete_in_time", {31'd0, k < 400}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_words(input int lim);
      int k = 0;
      while (exp_w.size() > lim && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("word_wait", {31'd0, k < 200}, 32'd1);
   endtask

   initial begin
      int d0, r0;
      for (int i = 0; i < N; i++) shadow_m[i] = 16'h4000;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {7'd0, outs()}, 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset contents, then async reset in the middle of a load.
      do_load();
      wait_quiet();
      cpu_write(2, 1'b1, 8'h12);
      do_load();
      repeat (5) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", {7'd0, outs()}, 32'd0);
      exp_w.delete();
      exp_d.delete();
      for (int i = 0; i < N; i++) shadow_m[i] = 16'h4000;
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      do_load();
      wait_quiet();

      // Basic load with latency and equalizer contents.
      for (int i = 0; i < N; i++) begin
         cpu_write(i, 1'b1, 8'((i + 1) * 8'h11));
         cpu_write(i, 1'b0, 8'((i + 1) * 8'h11));
      end
      r0 = n_rst;
      first_wr_cyc = -1;
      do_load();
      wait_quiet();
      chk("rst_pulses", n_rst - r0, 32'd1);
`ifndef EQ_LOAD_SYNC_EN
      chk("lat_wr_rst", rst_cyc - e0 + 1, 32'd2);
      chk("lat_first_wr", first_wr_cyc - e0 + 1, 32'd4);
      chk("lat_done", done_cyc - e0 + 1, 6 + 2 * (N - 1));
`endif
      chk("eq_addr_end", eq_addr, N);
      for (int i = 0; i < N; i++) chk("eq_ram", {16'd0, eq_ram[i]}, (i + 1) * 32'h1111);

      // CPU write to a not-yet-written entry lands in this load; out-of-range index ignored.
      shadow_m[3][15:8] = 8'hAB;
      do_load();
      wait_words(N - 2);
      cpu_write(3, 1'b1, 8'hAB);
      cpu_write(7, 1'b1, 8'h55);
      wait_quiet();
      chk("eq_ram_word3", {16'd0, eq_ram[3]}, 32'h0000AB44);
      do_load();
      wait_quiet();

      // Two requests during a load merge into one rerun with updated shadow.
      d0 = n_done;
      r0 = n_rst;
      do_load();
      wait_words(N - 1);
      cpu_write(0, 1'b0, 8'h99);
      pulse_req();
      repeat (2) @(posedge clk);
      #1;
      pulse_req();
      push_load(1'b0);
      wait_quiet();
      chk("merged_loads", n_done - d0, 32'd2);
      chk("merged_rsts", n_rst - r0, 32'd2);
      chk("rerun_word0", {16'd0, eq_ram[0]}, 32'h00001199);

      // Address sync failure is sticky until the next request.
      force_nz = 1'b1;
      push_load(1'b1);
      pulse_req();
      wait_quiet();
      chk("sync_err_sticky", {31'd0, sync_err}, 32'd1);
      force_nz = 1'b0;
      do_load();
      wait_quiet();
      chk("sync_err_cleared", {31'd0, sync_err}, 32'd0);

      // Randomized shadow traffic, sometimes with a rerun request mid-load.
      for (int r = 0; r < 8; r++) begin
         int nw;
         nw = $urandom_range(1, 4);
         for (int j = 0; j < nw; j++) begin
            cpu_write($urandom_range(0, 7), 1'($urandom_range(0, 1)), 8'($urandom));
         end
         do_load();
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 10)) @(posedge clk);
            #1;
            pulse_req();
            push_load(1'b0);
         end
         wait_quiet();
         chk("rand_eq_addr", eq_addr, N);
      end

`ifdef EQ_LOAD_SYNC_EN
      // Address reset follows the data-valid strobe by exactly one cycle.
      auto_dv = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      r0 = n_rst;
      do_load();
      repeat (20) @(posedge clk);
      #3;
      chk("no_rst_before_sync", n_rst - r0, 32'd0);
      dv_once = 1'b1;
      wait_quiet();
      chk("sync_rst_timing", rst_cyc, dv_cyc + 1);
      auto_dv = 1'b1;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1);
   end

endmodule
